// File: rtl/write_back_queue.sv
// -----------------------------------------------------------------------------
// write_back_queue
//
// Multi-channel write-back stage for the pipelined MIPS core. Each cycle up to
// NCH producer channels (channel 0 oldest) present a result. The data source
// of every channel is selected from ALU, load, link (npc) or immediate (ext).
// Results are queued in program order. Writes to $0 are dropped. The queue
// drains one entry per cycle into the register-file write port. NRD lookup
// ports search the pending entries for forwarding.
//
// Ports
//   CLK, nRST             clock (rising edge), asynchronous active-low reset
//   flush                 synchronous discard of all queued entries
//   in_valid[NCH]         per-channel write request
//   in_wreg[NCH*REG_W]    destination register per channel
//   in_src[NCH*2]         source select: 00 ALU, 01 load, 10 link, 11 imm
//   in_alu/in_mem/in_npc/in_ext[NCH*WORD_W]  candidate data per channel
//   in_ready              queue can take a full NCH-wide group this cycle
//   wb_ready              register file accepts the write this cycle
//   wb_en/wb_reg/wb_data  register-file write port (head of queue)
//   rd_reg[NRD*REG_W]     forwarding lookup register per port
//   rd_hit[NRD]           a pending write to rd_reg exists
//   rd_data[NRD*WORD_W]   data of the youngest pending write to rd_reg
//   occupancy             number of queued entries
// -----------------------------------------------------------------------------
module write_back_queue #(
  parameter int NCH    = 2,
  parameter int DEPTH  = 4,
  parameter int NRD    = 2,
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          flush,
  input  logic [NCH-1:0]                in_valid,
  input  logic [NCH*REG_W-1:0]          in_wreg,
  input  logic [NCH*2-1:0]              in_src,
  input  logic [NCH*WORD_W-1:0]         in_alu,
  input  logic [NCH*WORD_W-1:0]         in_mem,
  input  logic [NCH*WORD_W-1:0]         in_npc,
  input  logic [NCH*WORD_W-1:0]         in_ext,
  output logic                          in_ready,
  input  logic                          wb_ready,
  output logic                          wb_en,
  output logic [REG_W-1:0]              wb_reg,
  output logic [WORD_W-1:0]             wb_data,
  input  logic [NRD*REG_W-1:0]          rd_reg,
  output logic [NRD-1:0]                rd_hit,
  output logic [NRD*WORD_W-1:0]         rd_data,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int          CNT_W   = $clog2(DEPTH + 1);
  localparam int          PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DEPTH_U = DEPTH;
  localparam int unsigned NCH_U   = NCH;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LOAD = 2'b01,
    SRC_LINK = 2'b10,
    SRC_IMM  = 2'b11
  } src_e;

  // Pointer addition modulo DEPTH. The offset never exceeds DEPTH, so one
  // conditional subtraction is enough and DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base,
                                               input int unsigned      off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= DEPTH_U) sum = sum - DEPTH_U;
    return PTR_W'(sum);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [REG_W-1:0]  ent_reg  [DEPTH];
  logic [WORD_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_valid;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  // ---------------------------------------------------------------------------
  // Per-channel source selection
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] sel_data [NCH];

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      // NOTE: every combinational output gets a default before any branch, so
      // no path leaves it unassigned and no latch is inferred.
      sel_data[ch] = in_alu[ch*WORD_W +: WORD_W];
      case (src_e'(in_src[ch*2 +: 2]))
        SRC_ALU:  sel_data[ch] = in_alu[ch*WORD_W +: WORD_W];
        SRC_LOAD: sel_data[ch] = in_mem[ch*WORD_W +: WORD_W];
        SRC_LINK: sel_data[ch] = in_npc[ch*WORD_W +: WORD_W];
        SRC_IMM:  sel_data[ch] = in_ext[ch*WORD_W +: WORD_W];
        default:  sel_data[ch] = in_alu[ch*WORD_W +: WORD_W];
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic accept;
  logic pop;

  // Based on the registered count only: a pop in the same cycle earns no credit.
  assign in_ready  = (32'(count) + NCH_U) <= DEPTH_U;
  assign accept    = in_ready && (|in_valid) && !flush;
  assign wb_en     = (count != '0) && !flush;
  assign pop       = wb_en && wb_ready;
  assign occupancy = count;

  // Head entry is shown only while the queue holds something.
  assign wb_reg  = (count != '0) ? ent_reg[head]  : '0;
  assign wb_data = (count != '0) ? ent_data[head] : '0;

  // ---------------------------------------------------------------------------
  // Enqueue compaction: surviving channels take consecutive slots from tail
  // in ascending channel order; $0 writes consume no slot.
  // ---------------------------------------------------------------------------
  logic [NCH-1:0]   wr_en;
  logic [PTR_W-1:0] wr_idx [NCH];
  logic [CNT_W-1:0] push_num;

  always_comb begin
    int unsigned k;
    // NOTE: blocking assignments here model a running slot counter within one
    // evaluation; sequential state below uses non-blocking assignments only.
    k     = 0;
    wr_en = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      wr_idx[ch] = tail;
      if (accept && in_valid[ch] && (in_wreg[ch*REG_W +: REG_W] != '0)) begin
        wr_en[ch]  = 1'b1;
        wr_idx[ch] = ptr_add(tail, k);
        k          = k + 1;
      end
    end
    push_num = CNT_W'(k);
  end

  logic [DEPTH-1:0] valid_next;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    valid_next = ent_valid;
    if (pop) valid_next[head] = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (wr_en[ch]) valid_next[wr_idx[ch]] = 1'b1;
    end
    count_next = count + push_num - CNT_W'(pop);
  end

  // ---------------------------------------------------------------------------
  // Control registers: pointers, count and per-entry valid bits
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count     <= '0;
      head      <= '0;
      tail      <= '0;
      ent_valid <= '0;
    end else if (flush) begin
      count     <= '0;
      head      <= '0;
      tail      <= '0;
      ent_valid <= '0;
    end else begin
      count     <= count_next;
      ent_valid <= valid_next;
      if (pop)    head <= ptr_add(head, 1);
      if (accept) tail <= ptr_add(tail, 32'(push_num));
    end
  end

  // ---------------------------------------------------------------------------
  // Entry payload storage
  // ---------------------------------------------------------------------------
  // NOTE: payload arrays carry no reset; ent_valid and count qualify every
  // read, so stale contents are never observed at the outputs.
  always_ff @(posedge CLK) begin
    for (int ch = 0; ch < NCH; ch++) begin
      if (wr_en[ch]) begin
        ent_reg[wr_idx[ch]]  <= in_wreg[ch*REG_W +: REG_W];
        ent_data[wr_idx[ch]] <= sel_data[ch];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding lookup: walk from oldest (head) to youngest so the last match
  // wins. The entry being popped this cycle is still valid and still hits.
  // Inputs presented this cycle are not searched.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [REG_W-1:0] q;
    logic [PTR_W-1:0] idx;
    rd_hit  = '0;
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      q = rd_reg[i*REG_W +: REG_W];
      for (int unsigned j = 0; j < DEPTH_U; j++) begin
        idx = ptr_add(head, j);
        if ((q != '0) && ent_valid[idx] && (ent_reg[idx] == q)) begin
          rd_hit[i]                   = 1'b1;
          rd_data[i*WORD_W +: WORD_W] = ent_data[idx];
        end
      end
    end
  end

endmodule
